// File: rtl/prog_run_ctrl.sv
// Program loader and run sequencer for the datapath.
// Streams words into instruction memory, clears the datapath, then runs until HLT or watchdog.
module prog_run_ctrl #(
  parameter int IMEM_DEPTH  = 256,
  parameter int CLR_CYCLES  = 2,
  parameter int WDOG_CYCLES = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_start,
  input  logic             run_start,
  input  logic             abort,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [15:0]      load_data,
  input  logic             load_last,
  input  logic             halt_in,
  output logic             test_normal,
  output logic             ext_instr_we,
  output logic [15:0]      ext_instr_addr,
  output logic [15:0]      ext_instr_data,
  output logic             dp_clr,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [15:0]      words_loaded,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_HALT
  } state_t;

  localparam logic [15:0] LAST_PTR = 16'(IMEM_DEPTH - 1);
  localparam logic [15:0] CLR_LAST = 16'(CLR_CYCLES - 1);

  state_t           state, n_state;
  logic             fin, n_fin;
  logic [15:0]      clr_cnt, n_clr_cnt;
  logic             n_lr, n_tn, n_we, n_dc, n_busy, n_done, n_to;
  logic [15:0]      n_addr, n_data, n_wl;
  logic [CNT_W-1:0] n_cc;
  logic             wdog_hit;

  assign wdog_hit = (WDOG_CYCLES != 0) &&
                    (32'(cycle_count) == 32'(WDOG_CYCLES - 1));

  always_comb begin
    n_state   = state;
    n_fin     = fin;
    n_clr_cnt = clr_cnt;
    n_lr      = load_ready;
    n_tn      = test_normal;
    n_we      = 1'b0;
    n_addr    = ext_instr_addr;
    n_data    = ext_instr_data;
    n_dc      = dp_clr;
    n_done    = done;
    n_to      = timeout;
    n_wl      = words_loaded;
    n_cc      = cycle_count;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (load_start) begin
          n_state = S_LOAD;
          n_lr    = 1'b1;
          n_tn    = 1'b1;
          n_fin   = 1'b0;
          n_wl    = 16'd0;
          n_done  = 1'b0;
          n_to    = 1'b0;
        end else if (run_start) begin
          n_state   = S_CLEAR;
          n_tn      = 1'b0;
          n_dc      = 1'b1;
          n_clr_cnt = 16'd0;
          n_done    = 1'b0;
          n_to      = 1'b0;
          n_cc      = '0;
        end
      end
      S_LOAD: begin
        if (fin) begin
          n_state = S_IDLE;
          n_fin   = 1'b0;
          n_lr    = 1'b0;
        end else if (load_valid && load_ready) begin
          n_we   = 1'b1;
          n_addr = words_loaded;
          n_data = load_data;
          n_wl   = words_loaded + 16'd1;
          // Final word: stop accepting, leave after its write cycle
          if (load_last || words_loaded == LAST_PTR) begin
            n_fin = 1'b1;
            n_lr  = 1'b0;
          end
        end
      end
      S_CLEAR: begin
        n_clr_cnt = clr_cnt + 16'd1;
        if (clr_cnt == CLR_LAST) begin
          n_state = S_RUN;
          n_dc    = 1'b0;
        end
      end
      S_RUN: begin
        n_cc = (&cycle_count) ? cycle_count
                              : cycle_count + CNT_W'(1);
        if (halt_in) begin
          n_state = S_HALT;
          n_done  = 1'b1;
          n_tn    = 1'b1;
        end else if (wdog_hit) begin
          n_state = S_HALT;
          n_to    = 1'b1;
          n_tn    = 1'b1;
        end
      end
      default: n_state = S_IDLE;
    endcase
    if (abort) begin
      n_state = S_IDLE;
      n_fin   = 1'b0;
      n_lr    = 1'b0;
      n_tn    = 1'b1;
      n_we    = 1'b0;
      n_dc    = 1'b0;
      n_addr  = ext_instr_addr;
      n_data  = ext_instr_data;
      n_done  = done;
      n_to    = timeout;
      n_wl    = words_loaded;
      n_cc    = cycle_count;
    end
    n_busy = (n_state == S_LOAD) || (n_state == S_CLEAR) ||
             (n_state == S_RUN);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state          <= S_IDLE;
      fin            <= 1'b0;
      clr_cnt        <= 16'd0;
      load_ready     <= 1'b0;
      test_normal    <= 1'b1;
      ext_instr_we   <= 1'b0;
      ext_instr_addr <= 16'd0;
      ext_instr_data <= 16'd0;
      dp_clr         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      words_loaded   <= 16'd0;
      cycle_count    <= '0;
    end else begin
      state          <= n_state;
      fin            <= n_fin;
      clr_cnt        <= n_clr_cnt;
      load_ready     <= n_lr;
      test_normal    <= n_tn;
      ext_instr_we   <= n_we;
      ext_instr_addr <= n_addr;
      ext_instr_data <= n_data;
      dp_clr         <= n_dc;
      busy           <= n_busy;
      done           <= n_done;
      timeout        <= n_to;
      words_loaded   <= n_wl;
      cycle_count    <= n_cc;
    end
  end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed vector bench for prog_run_ctrl.
// Small memory and watchdog so the depth and timeout cases are short.
module tb_prog_run_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        load_start = 1'b0, run_start = 1'b0, abort = 1'b0;
  logic        load_valid = 1'b0, load_last = 1'b0, halt_in = 1'b0;
  logic [15:0] load_data = 16'h0;
  logic        load_ready, test_normal, ext_instr_we, dp_clr;
  logic        busy, done, timeout;
  logic [15:0] ext_instr_addr, ext_instr_data, words_loaded;
  logic [15:0] cycle_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prog_run_ctrl #(
    .IMEM_DEPTH(4), .CLR_CYCLES(2), .WDOG_CYCLES(16), .CNT_W(16)
  ) dut (
    .clk(clk), .clr(clr),
    .load_start(load_start), .run_start(run_start), .abort(abort),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .halt_in(halt_in),
    .test_normal(test_normal), .ext_instr_we(ext_instr_we),
    .ext_instr_addr(ext_instr_addr), .ext_instr_data(ext_instr_data),
    .dp_clr(dp_clr), .busy(busy), .done(done), .timeout(timeout),
    .words_loaded(words_loaded), .cycle_count(cycle_count)
  );

  typedef struct {
    logic        ls, rs, ab, lv, ll, hi;
    logic [15:0] ld;
    logic        lr, tn, we;
    logic [15:0] ad, dt;
    logic        dc, bs, dn, to;
    logic [15:0] wl, cc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic ls, rs, ab, lv, ll, hi, input logic [15:0] ld,
    input logic lr, tn, we, input logic [15:0] ad, dt,
    input logic dc, bs, dn, to, input logic [15:0] wl, cc);
    vec_t v;
    v.ls = ls; v.rs = rs; v.ab = ab; v.lv = lv; v.ll = ll; v.hi = hi;
    v.ld = ld; v.lr = lr; v.tn = tn; v.we = we; v.ad = ad; v.dt = dt;
    v.dc = dc; v.bs = bs; v.dn = dn; v.to = to; v.wl = wl; v.cc = cc;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input vec_t v);
    logic [72:0] g, e;
    g = {load_ready, test_normal, ext_instr_we, dp_clr, busy, done,
         timeout, words_loaded, cycle_count,
         v.we ? {ext_instr_addr, ext_instr_data} : 32'h0};
    e = {v.lr, v.tn, v.we, v.dc, v.bs, v.dn, v.to, v.wl, v.cc,
         v.we ? {v.ad, v.dt} : 32'h0};
    n_vec++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s got lr/tn/we/dc/bs/dn/to/wl/cc/ad/dt=%h want %h",
               nm, g, e);
    end
  endtask

  task automatic drive(input vec_t v);
    load_start = v.ls; run_start = v.rs; abort = v.ab;
    load_valid = v.lv; load_last = v.ll; halt_in = v.hi;
    load_data = v.ld;
  endtask

  initial begin
    vec_t z, r;
    // 3-word load
    add(1,0,0,0,0,0,0,      1,1,0,0,0,        0,1,0,0,0,0);
    add(0,0,0,1,0,0,'h1900, 1,1,1,0,'h1900,   0,1,0,0,1,0);
    add(0,0,0,1,0,0,'hE020, 1,1,1,1,'hE020,   0,1,0,0,2,0);
    add(0,0,0,1,1,0,'h0956, 0,1,1,2,'h0956,   0,1,0,0,3,0);
    add(0,0,0,0,0,0,0,      0,1,0,0,0,        0,0,0,0,3,0);
    // run, halt on 5th RUN cycle
    add(0,1,0,0,0,0,0,      0,0,0,0,0,        1,1,0,0,3,0);
    add(0,0,0,0,0,0,0,      0,0,0,0,0,        1,1,0,0,3,0);
    add(0,0,0,0,0,0,0,      0,0,0,0,0,        0,1,0,0,3,0);
    for (int i = 1; i < 5; i++)
      add(0,0,0,0,0,0,0,    0,0,0,0,0,        0,1,0,0,3,16'(i));
    add(0,0,0,0,0,1,0,      0,1,0,0,0,        0,0,1,0,3,5);
    add(0,0,0,0,0,1,0,      0,1,0,0,0,        0,0,1,0,3,5);
    // watchdog
    add(0,1,0,0,0,0,0,      0,0,0,0,0,        1,1,0,0,3,0);
    add(0,0,0,0,0,0,0,      0,0,0,0,0,        1,1,0,0,3,0);
    add(0,0,0,0,0,0,0,      0,0,0,0,0,        0,1,0,0,3,0);
    for (int i = 1; i < 16; i++)
      add(0,0,0,0,0,0,0,    0,0,0,0,0,        0,1,0,0,3,16'(i));
    add(0,0,0,0,0,0,0,      0,1,0,0,0,        0,0,0,1,3,16);
    // depth limit: 6 words, no last
    add(1,0,0,0,0,0,0,      1,1,0,0,0,        0,1,0,0,0,16);
    for (int i = 0; i < 4; i++)
      add(0,0,0,1,0,0,16'('hA000 + i), (i < 3), 1, 1, 16'(i),
          16'('hA000 + i),                    0,1,0,0,16'(i + 1),16);
    add(0,0,0,1,0,0,'hA004, 0,1,0,0,0,        0,0,0,0,4,16);
    add(0,0,0,1,0,0,'hA005, 0,1,0,0,0,        0,0,0,0,4,16);
    // toggling valid
    add(1,0,0,0,0,0,0,      1,1,0,0,0,        0,1,0,0,0,16);
    add(0,0,0,1,0,0,'hB000, 1,1,1,0,'hB000,   0,1,0,0,1,16);
    add(0,0,0,0,0,0,0,      1,1,0,0,0,        0,1,0,0,1,16);
    add(0,0,0,1,0,0,'hB001, 1,1,1,1,'hB001,   0,1,0,0,2,16);
    add(0,0,0,0,0,0,0,      1,1,0,0,0,        0,1,0,0,2,16);
    add(0,0,0,1,1,0,'hB002, 0,1,1,2,'hB002,   0,1,0,0,3,16);
    add(0,0,0,0,0,0,0,      0,1,0,0,0,        0,0,0,0,3,16);
    // abort on 2nd LOAD cycle, reload restarts at 0
    add(1,0,0,0,0,0,0,      1,1,0,0,0,        0,1,0,0,0,16);
    add(0,0,0,1,0,0,'hC000, 1,1,1,0,'hC000,   0,1,0,0,1,16);
    add(0,0,1,1,0,0,'hC001, 0,1,0,0,0,        0,0,0,0,1,16);
    add(1,0,0,0,0,0,0,      1,1,0,0,0,        0,1,0,0,0,16);
    add(0,0,0,1,1,0,'hD000, 0,1,1,0,'hD000,   0,1,0,0,1,16);
    add(0,0,0,0,0,0,0,      0,1,0,0,0,        0,0,0,0,1,16);
    add(0,1,1,0,0,0,0,      0,1,0,0,0,        0,0,0,0,1,16);
    // halt coincides with watchdog
    add(0,1,0,0,0,0,0,      0,0,0,0,0,        1,1,0,0,1,0);
    add(0,0,0,0,0,0,0,      0,0,0,0,0,        1,1,0,0,1,0);
    add(0,0,0,0,0,0,0,      0,0,0,0,0,        0,1,0,0,1,0);
    for (int i = 1; i < 16; i++)
      add(0,0,0,0,0,0,0,    0,0,0,0,0,        0,1,0,0,1,16'(i));
    add(0,0,0,0,0,1,0,      0,1,0,0,0,        0,0,1,0,1,16);
    // load beats run; abort from LOAD
    add(1,1,0,0,0,0,0,      1,1,0,0,0,        0,1,0,0,0,16);
    add(0,0,1,0,0,0,0,      0,1,0,0,0,        0,0,0,0,0,16);

    z = '{default: '0};
    z.tn = 1'b1;
    #12;
    check("reset", z);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), tbl[i]);
    end

    // async clr in the middle of a run
    r = '{default: '0};
    r.rs = 1'b1;
    drive(r);
    @(posedge clk); #1;
    r.rs = 1'b0;
    drive(r);
    repeat (4) begin @(posedge clk); #1; end
    r.bs = 1'b1; r.cc = 16'd2;
    check("run_before_clr", r);
    #2 clr = 1'b1;
    #1 check("clr_in_run", z);
    @(negedge clk);
    clr = 1'b0;
    r = '{default: '0};
    r.ls = 1'b1;
    drive(r);
    @(posedge clk); #1;
    r.ls = 1'b0; r.lv = 1'b1; r.ll = 1'b1; r.ld = 16'hE000;
    drive(r);
    @(posedge clk); #1;
    r.tn = 1'b1; r.we = 1'b1; r.ad = 16'h0; r.dt = 16'hE000;
    r.bs = 1'b1; r.wl = 16'd1;
    check("reload_after_clr", r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
